// File: rtl/sdrc_mon_pkg.sv
// Shared types for the SDRAM bus monitor: command decode, transaction states, error and
// counter bit positions.
package sdrc_mon_pkg;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS, CMD_BST
  } sdr_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_WAIT_ACK, ST_WR_BURST, ST_RD_BURST
  } mon_state_e;

  localparam int ERR_ACT_OPEN  = 0;
  localparam int ERR_RW_CLOSED = 1;
  localparam int ERR_REF_OPEN  = 2;
  localparam int ERR_NO_INIT   = 3;
  localparam int ERR_BURST_LEN = 4;
  localparam int ERR_ACK_TMO   = 5;
  localparam int ERR_W         = 6;

  localparam int CNT_ACT = 0;
  localparam int CNT_RD  = 1;
  localparam int CNT_WR  = 2;
  localparam int CNT_PRE = 3;
  localparam int CNT_REF = 4;
  localparam int NUM_CNT = 5;

  function automatic sdr_cmd_e sdr_decode(input logic cs_n, input logic ras_n,
                                          input logic cas_n, input logic we_n);
    sdr_cmd_e c;
    c = CMD_NOP;
    if (!cs_n) begin
      case ({ras_n, cas_n, we_n})
        3'b011:  c = CMD_ACT;
        3'b101:  c = CMD_RD;
        3'b100:  c = CMD_WR;
        3'b010:  c = CMD_PRE;
        3'b001:  c = CMD_REF;
        3'b000:  c = CMD_MRS;
        3'b110:  c = CMD_BST;
        default: c = CMD_NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/sdrc_bank_tracker.sv
// Per-bank open/closed tracking from decoded SDRAM commands, plus the bank-state protocol
// violations seen against the state held before the command.
module sdrc_bank_tracker
  import sdrc_mon_pkg::*;
#(
  parameter int NUM_BANK = 4,
  parameter int BA_W     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  sdr_cmd_e            cmd,
  input  logic [BA_W-1:0]     ba,
  input  logic                a10,
  output logic [NUM_BANK-1:0] bank_open,
  output logic [2:0]          err_hit
);

  logic [NUM_BANK-1:0] open_q, open_d;

  always_comb begin
    open_d = open_q;
    case (cmd)
      CMD_ACT: open_d[ba] = 1'b1;
      CMD_PRE: begin
        if (a10) open_d = '0;
        else     open_d[ba] = 1'b0;
      end
      // auto-precharge closes the bank in the same cycle as the access
      CMD_RD, CMD_WR: if (a10) open_d[ba] = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) open_q <= '0;
    else        open_q <= open_d;
  end

  assign err_hit[ERR_ACT_OPEN]  = (cmd == CMD_ACT) && open_q[ba];
  assign err_hit[ERR_RW_CLOSED] = ((cmd == CMD_RD) || (cmd == CMD_WR)) && !open_q[ba];
  assign err_hit[ERR_REF_OPEN]  = (cmd == CMD_REF) && (|open_q);
  assign bank_open              = open_q;

endmodule

// File: rtl/sdrc_bus_monitor.sv
// Passive SDRAM bus monitor: command counters, bank tracking, app-side burst framing and
// request->ack latency, with sticky error flags.
module sdrc_bus_monitor
  import sdrc_mon_pkg::*;
#(
  parameter int APP_AW   = 26,
  parameter int BL_W     = 9,
  parameter int BA_W     = 2,
  parameter int NUM_BANK = 4,
  parameter int ROW_W    = 13,
  parameter int CNT_W    = 32,
  parameter int LAT_W    = 16,
  parameter int TMO_CYC  = 1024
) (
  input  logic                sdram_clk,
  input  logic                sdram_resetn,
  input  logic                mon_en,
  input  logic                clr_cnt,
  input  logic                sdr_init_done,
  input  logic                app_req,
  input  logic                app_req_ack,
  input  logic                app_req_wr_n,
  input  logic [BL_W-1:0]     app_req_len,
  input  logic                app_wr_next_req,
  input  logic                app_rd_valid,
  input  logic                app_last_wr,
  input  logic                app_last_rd,
  input  logic                sdr_cs_n,
  input  logic                sdr_ras_n,
  input  logic                sdr_cas_n,
  input  logic                sdr_we_n,
  input  logic [BA_W-1:0]     sdr_ba,
  input  logic [ROW_W-1:0]    sdr_addr,
  output logic [CNT_W-1:0]    cnt_act,
  output logic [CNT_W-1:0]    cnt_rd,
  output logic [CNT_W-1:0]    cnt_wr,
  output logic [CNT_W-1:0]    cnt_pre,
  output logic [CNT_W-1:0]    cnt_ref,
  output logic [LAT_W-1:0]    lat_last,
  output logic [LAT_W-1:0]    lat_max,
  output logic [NUM_BANK-1:0] bank_open,
  output logic [ERR_W-1:0]    err_flags,
  output logic                err_pulse
);

  sdr_cmd_e                      cmd;
  logic [2:0]                    bank_err;
  mon_state_e                    state_q, state_d;
  logic [LAT_W-1:0]              lat_q, lat_d, lat_inc;
  logic [LAT_W-1:0]              lat_last_q, lat_last_d, lat_max_q, lat_max_d;
  logic [BL_W-1:0]               len_q, len_d;
  logic [BL_W:0]                 beats_q, beats_d, beats_now;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CNT-1:0]            inc;
  logic [ERR_W-1:0]              err_q, err_d, err_new;
  logic                          pulse_q, pulse_d;
  logic                          acked, len_bad, tmo, in_wr, beat, last;
  logic [31:0]                   unused_aw;
  logic                          unused_addr;

  assign unused_aw   = APP_AW;
  assign unused_addr = ^{sdr_addr[ROW_W-1:11], sdr_addr[9:0]};

  assign cmd = sdr_decode(sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n);

  sdrc_bank_tracker #(.NUM_BANK(NUM_BANK), .BA_W(BA_W)) u_bank (
    .clk       (sdram_clk),
    .rst_n     (sdram_resetn),
    .cmd       (cmd),
    .ba        (sdr_ba),
    .a10       (sdr_addr[10]),
    .bank_open (bank_open),
    .err_hit   (bank_err)
  );

  // Burst phase shares one beat/last path, selected by direction.
  assign in_wr     = (state_q == ST_WR_BURST);
  assign beat      = in_wr ? app_wr_next_req : app_rd_valid;
  assign last      = in_wr ? app_last_wr : app_last_rd;
  assign beats_now = beats_q + {{BL_W{1'b0}}, beat};
  assign lat_inc   = (lat_q == '1) ? lat_q : lat_q + LAT_W'(1);

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    len_d   = len_q;
    beats_d = beats_q;
    acked   = 1'b0;
    len_bad = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (app_req) begin
          state_d = ST_WAIT_ACK;
          lat_d   = LAT_W'(1);
        end
      end
      ST_WAIT_ACK: begin
        if (app_req && app_req_ack) begin
          acked   = 1'b1;
          len_d   = app_req_len;
          beats_d = '0;
          state_d = app_req_wr_n ? ST_RD_BURST : ST_WR_BURST;
        end else if (!app_req) begin
          state_d = ST_IDLE;
        end else begin
          lat_d = lat_inc;
          // lat_q passes TMO_CYC exactly once per request, so this flags once
          tmo   = (lat_q == LAT_W'(TMO_CYC));
        end
      end
      ST_WR_BURST, ST_RD_BURST: begin
        if (last) begin
          len_bad = (beats_now != {1'b0, len_q});
          if (app_req) begin
            state_d = ST_WAIT_ACK;
            lat_d   = LAT_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          beats_d = beats_now;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    inc = '0;
    case (cmd)
      CMD_ACT: inc[CNT_ACT] = 1'b1;
      CMD_RD:  inc[CNT_RD]  = 1'b1;
      CMD_WR:  inc[CNT_WR]  = 1'b1;
      CMD_PRE: inc[CNT_PRE] = 1'b1;
      CMD_REF: inc[CNT_REF] = 1'b1;
      default: ;
    endcase
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_cnt)                                  cnt_d[i] = '0;
      else if (mon_en && inc[i] && cnt_q[i] != '1)  cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  always_comb begin
    err_new = '0;
    if (mon_en) begin
      err_new[ERR_REF_OPEN:ERR_ACT_OPEN] = bank_err;
      err_new[ERR_NO_INIT]   = !sdr_init_done &&
                               ((cmd == CMD_ACT) || (cmd == CMD_RD) || (cmd == CMD_WR));
      err_new[ERR_BURST_LEN] = len_bad;
      err_new[ERR_ACK_TMO]   = tmo;
    end
    err_d      = err_q | err_new;
    pulse_d    = |(err_new & ~err_q);
    lat_last_d = lat_last_q;
    lat_max_d  = lat_max_q;
    if (mon_en && acked) begin
      lat_last_d = lat_q;
      if (lat_q > lat_max_q) lat_max_d = lat_q;
    end
    if (clr_cnt) begin
      err_d      = '0;
      pulse_d    = 1'b0;
      lat_last_d = '0;
      lat_max_d  = '0;
    end
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state_q    <= ST_IDLE;
      lat_q      <= '0;
      len_q      <= '0;
      beats_q    <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
      pulse_q    <= 1'b0;
      lat_last_q <= '0;
      lat_max_q  <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      len_q      <= len_d;
      beats_q    <= beats_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      pulse_q    <= pulse_d;
      lat_last_q <= lat_last_d;
      lat_max_q  <= lat_max_d;
    end
  end

  assign cnt_act   = cnt_q[CNT_ACT];
  assign cnt_rd    = cnt_q[CNT_RD];
  assign cnt_wr    = cnt_q[CNT_WR];
  assign cnt_pre   = cnt_q[CNT_PRE];
  assign cnt_ref   = cnt_q[CNT_REF];
  assign lat_last  = lat_last_q;
  assign lat_max   = lat_max_q;
  assign err_flags = err_q;
  assign err_pulse = pulse_q;

endmodule
